triangle_render: RTL

Triangle rasterizer that accepts three 3-bit vertices over a `nt`/`busy` handshake and emits every grid point inside or on the triangle. It scans the bounding box and presents one candidate point per cycle. It is the responder to the triangle stimulus generator, the block under test that the generator drives through `nt`/`xi`/`yi` and paces on `busy`.

---
 rtl/triangle_render_if.sv | 15 +
 rtl/triangle_render.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/triangle_render_if.sv
// Vertex-in / pixel-out bus between the triangle stimulus generator and the rasterizer.
interface triangle_render_if;
    localparam int unsigned CW = 3;

    logic          nt;
    logic [CW-1:0] xi;
    logic [CW-1:0] yi;
    logic          busy;
    logic          po;
    logic [CW-1:0] xo;
    logic [CW-1:0] yo;

    modport master (output nt, xi, yi, input busy, po, xo, yo);
    modport slave  (input nt, xi, yi, output busy, po, xo, yo);
endinterface

// File: rtl/triangle_render.sv
// Triangle rasterizer: collects three vertices, scans their bounding box one point per
// cycle and strobes po for every point on or inside the triangle (edge-function sign test).
module triangle_render (
    input  logic              clk,
    input  logic              reset,
    triangle_render_if.slave  bus
);
    localparam int unsigned CW = 3;
    localparam int unsigned DW = 4;
    localparam int unsigned PW = 7;
    localparam int unsigned EW = 8;

    typedef enum logic [2:0] {S_IDLE, S_GET2, S_GET3, S_SCAN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] x1_q, y1_q, x2_q, y2_q, x3_q, y3_q;
    logic [CW-1:0] x1_d, y1_d, x2_d, y2_d, x3_d, y3_d;
    logic [CW-1:0] xmin_q, xmax_q, ymax_q, xmin_d, xmax_d, ymax_d;
    logic [CW-1:0] cx_q, cy_q, cx_d, cy_d;
    logic          busy_q, po_q, busy_d, po_d;
    logic [CW-1:0] xo_q, yo_q, xo_d, yo_d;

    logic [CW-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic signed [EW-1:0] e12, e23, e31;
    logic          inside_c;

    // Signed edge function (bx-ax)(py-ay) - (by-ay)(px-ax); ranges fit without overflow
    function automatic logic signed [EW-1:0] edge_fn(
        input logic [CW-1:0] ax, input logic [CW-1:0] ay,
        input logic [CW-1:0] bx, input logic [CW-1:0] by,
        input logic [CW-1:0] px, input logic [CW-1:0] py);
        logic signed [DW-1:0] dx_ab, dy_ab, dx_ap, dy_ap;
        logic signed [PW-1:0] p0, p1;
        dx_ab = $signed({1'b0, bx}) - $signed({1'b0, ax});
        dy_ab = $signed({1'b0, by}) - $signed({1'b0, ay});
        dx_ap = $signed({1'b0, px}) - $signed({1'b0, ax});
        dy_ap = $signed({1'b0, py}) - $signed({1'b0, ay});
        p0 = PW'(dx_ab) * PW'(dy_ap);
        p1 = PW'(dy_ab) * PW'(dx_ap);
        return EW'(p0) - EW'(p1);
    endfunction

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                           input logic [CW-1:0] c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Bounding box uses the live third vertex so the scan can start right after GET3
    assign bb_xmin = min3(x1_q, x2_q, bus.xi);
    assign bb_xmax = max3(x1_q, x2_q, bus.xi);
    assign bb_ymin = min3(y1_q, y2_q, bus.yi);
    assign bb_ymax = max3(y1_q, y2_q, bus.yi);

    assign e12 = edge_fn(x1_q, y1_q, x2_q, y2_q, cx_q, cy_q);
    assign e23 = edge_fn(x2_q, y2_q, x3_q, y3_q, cx_q, cy_q);
    assign e31 = edge_fn(x3_q, y3_q, x1_q, y1_q, cx_q, cy_q);

    // Same sign on all three edges covers both windings; zero counts as either sign
    assign inside_c = (!e12[EW-1] && !e23[EW-1] && !e31[EW-1]) ||
                      ((e12[EW-1] || e12 == '0) && (e23[EW-1] || e23 == '0) &&
                       (e31[EW-1] || e31 == '0));

    always_comb begin
        state_d = state_q;
        x1_d = x1_q; y1_d = y1_q;
        x2_d = x2_q; y2_d = y2_q;
        x3_d = x3_q; y3_d = y3_q;
        xmin_d = xmin_q; xmax_d = xmax_q; ymax_d = ymax_q;
        cx_d = cx_q; cy_d = cy_q;
        busy_d = busy_q; po_d = po_q;
        xo_d = xo_q; yo_d = yo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.nt) begin
                    x1_d    = bus.xi;
                    y1_d    = bus.yi;
                    busy_d  = 1'b1;
                    state_d = S_GET2;
                end
            end
            S_GET2: begin
                x2_d    = bus.xi;
                y2_d    = bus.yi;
                state_d = S_GET3;
            end
            S_GET3: begin
                x3_d    = bus.xi;
                y3_d    = bus.yi;
                xmin_d  = bb_xmin;
                xmax_d  = bb_xmax;
                ymax_d  = bb_ymax;
                cx_d    = bb_xmin;
                cy_d    = bb_ymin;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                po_d = inside_c;
                xo_d = cx_q;
                yo_d = cy_q;
                if (cx_q == xmax_q) begin
                    if (cy_q == ymax_q) begin
                        state_d = S_DONE;
                    end else begin
                        cx_d = xmin_q;
                        cy_d = cy_q + CW'(1);
                    end
                end else begin
                    cx_d = cx_q + CW'(1);
                end
            end
            S_DONE: begin
                po_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x1_q <= '0; y1_q <= '0;
            x2_q <= '0; y2_q <= '0;
            x3_q <= '0; y3_q <= '0;
            xmin_q <= '0; xmax_q <= '0; ymax_q <= '0;
            cx_q <= '0; cy_q <= '0;
            busy_q <= 1'b0; po_q <= 1'b0;
            xo_q <= '0; yo_q <= '0;
        end else begin
            state_q <= state_d;
            x1_q <= x1_d; y1_q <= y1_d;
            x2_q <= x2_d; y2_q <= y2_d;
            x3_q <= x3_d; y3_q <= y3_d;
            xmin_q <= xmin_d; xmax_q <= xmax_d; ymax_q <= ymax_d;
            cx_q <= cx_d; cy_q <= cy_d;
            busy_q <= busy_d; po_q <= po_d;
            xo_q <= xo_d; yo_q <= yo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.po   = po_q;
    assign bus.xo   = xo_q;
    assign bus.yo   = yo_q;
endmodule
